// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM state codes, access sizes
// and the alignment rule used when a request is accepted.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RMW,
        ST_WR,
        ST_DONE
    } state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_R = 2'b11;

    // Reserved size or natural-alignment violation.
    function automatic logic bad_access(input logic [1:0] size,
                                        input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        unique case (1'b1)
            (size == SIZE_R): bad = 1'b1;
            (size == SIZE_H): bad = lo[0];
            (size == SIZE_W): bad = (lo != 2'b00);
            default:          bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Lane logic: extract+extend a load from the memory word, merge store data.
// Ports: mem_rdata_i word, lane_i addr[1:0], size_i, unsigned_i, wdata_i; load_o, merge_o.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] mem_rdata_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sgn_b;
    logic        sgn_h;

    always_comb begin
        shifted = mem_rdata_i >> {lane_i, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = lane_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        sgn_b   = ~unsigned_i & byte_v[7];
        sgn_h   = ~unsigned_i & half_v[15];
        load_o  = mem_rdata_i;
        merge_o = mem_rdata_i;
        unique case (1'b1)
            (size_i == SIZE_B): begin
                load_o = {{24{sgn_b}}, byte_v};
                merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            (size_i == SIZE_H): begin
                load_o = {{16{sgn_h}}, half_v};
                if (lane_i[1]) merge_o[31:16] = wdata_i[15:0];
                else           merge_o[15:0]  = wdata_i[15:0];
            end
            default: begin
                load_o  = mem_rdata_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store sequencer in front of a 32-bit little-endian memory.
// Ports: CLK, Reset_n, Start/Store/Size/Unsigned/Addr/WData request in;
//   Busy/Done/AddrErr/RData status out; MemRW/MemAddr/MemWData/MemRData memory side.
// Define LSU_BOUND_CHECK_EN to also flag word addresses beyond MEM_BYTES-4.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic        Store,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic        Busy,
    output logic        Done,
    output logic        AddrErr,
    output logic [31:0] RData,
    output logic        MemRW,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData
);

`ifdef LSU_BOUND_CHECK_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif
    localparam logic [31:0] MEM_LAST = 32'(MEM_BYTES - 4);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        store_q, store_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mwdata_q, mwdata_d;

    logic        req_err;
    logic        oob;
    logic [31:0] ld_data;
    logic [31:0] st_merge;

    assign oob     = {Addr[31:2], 2'b00} > MEM_LAST;
    assign req_err = bad_access(Size, Addr[1:0]) | (BOUND_EN & oob);

    load_store_unit_align u_align (
        .mem_rdata_i (MemRData),
        .lane_i      (addr_q[1:0]),
        .size_i      (size_q),
        .unsigned_i  (uns_q),
        .wdata_i     (wdata_q),
        .load_o      (ld_data),
        .merge_o     (st_merge)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        store_d  = store_q;
        size_d   = size_q;
        uns_d    = uns_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        mwdata_d = mwdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    addr_d  = Addr;
                    wdata_d = WData;
                    store_d = Store;
                    size_d  = Size;
                    uns_d   = Unsigned;
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = ST_DONE;
                    end else if (!Store) begin
                        state_d = ST_RD;
                    end else if (Size == SIZE_W) begin
                        state_d  = ST_WR;
                        mwdata_d = WData;
                    end else begin
                        state_d = ST_RMW;
                    end
                end
            end
            ST_RD: begin
                rdata_d = ld_data;
                state_d = ST_DONE;
            end
            ST_RMW: begin
                // Memory writes whole words: merge new lane into current word.
                mwdata_d = st_merge;
                state_d  = ST_WR;
            end
            ST_WR:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            store_q  <= 1'b0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            store_q  <= store_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            mwdata_q <= mwdata_d;
        end
    end

    assign Busy     = (state_q != ST_IDLE);
    assign Done     = (state_q == ST_DONE);
    assign AddrErr  = Done & err_q;
    assign RData    = rdata_q;
    assign MemRW    = (state_q == ST_WR) & store_q;
    assign MemAddr  = {addr_q[31:2], 2'b00};
    assign MemWData = mwdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model,
// directed cases, reset-mid-operation cases and randomized requests.
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic        Store = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic        Unsigned = 1'b0;
    logic [31:0] Addr = '0;
    logic [31:0] WData = '0;
    logic        Busy, Done, AddrErr, MemRW;
    logic [31:0] RData, MemAddr, MemWData, MemRData;

    logic [7:0] mem     [0:1023];
    logic [7:0] ref_mem [0:1023];

    always #5 CLK = ~CLK;

    load_store_unit #(.MEM_BYTES(1024)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .Store(Store),
        .Size(Size), .Unsigned(Unsigned), .Addr(Addr), .WData(WData),
        .Busy(Busy), .Done(Done), .AddrErr(AddrErr), .RData(RData),
        .MemRW(MemRW), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData)
    );

    // Memory: combinational read, full-word write on posedge.
    assign MemRData = {mem[{MemAddr[9:2], 2'd3}], mem[{MemAddr[9:2], 2'd2}],
                       mem[{MemAddr[9:2], 2'd1}], mem[{MemAddr[9:2], 2'd0}]};
    always @(posedge CLK) begin
        if (MemRW) begin
            mem[{MemAddr[9:2], 2'd0}] <= MemWData[7:0];
            mem[{MemAddr[9:2], 2'd1}] <= MemWData[15:8];
            mem[{MemAddr[9:2], 2'd2}] <= MemWData[23:16];
            mem[{MemAddr[9:2], 2'd3}] <= MemWData[31:24];
        end
    end

    int cyc = 0;
    int wr_cnt = 0;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(posedge CLK) if (MemRW) wr_cnt <= wr_cnt + 1;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          issue;
        int          lat;
        int          writes;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          exp_writes = 0;
    logic [31:0] last_rdata = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int mem_diff();
        int n = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    function automatic logic [31:0] mem_word(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    // Monitor: every Done pops one expectation.
    always @(negedge CLK) begin
        if (Reset_n && Done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_adderr"}, 32'(AddrErr), 32'(mon_e.err));
                chk({mon_e.name, "_rdata"}, RData, mon_e.rdata);
                chk({mon_e.name, "_latency"}, cyc - mon_e.issue, mon_e.lat);
                chk({mon_e.name, "_writes"}, wr_cnt, mon_e.writes);
                chk({mon_e.name, "_mem"}, mem_diff(), 0);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 20 && Busy; i++) begin
            @(negedge CLK);
            #2;
        end
        if (Busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic do_op(input string nm, input bit st, input logic [1:0] sz,
                         input bit un, input logic [31:0] a,
                         input logic [31:0] wd, input bit poke);
        exp_t        e;
        bit          err;
        int          b;
        logic [31:0] v;
        wait_idle();
        err = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
              (sz == 2'd2 && a[1:0] != 2'd0);
`ifdef LSU_BOUND_CHECK_EN
        err = err || ((a & ~32'd3) > 32'd1020);
`endif
        b = int'(a[9:0]);
        if (err) begin
            e.lat = 1;
        end else if (!st) begin
            if (sz == 2'd0) begin
                v = 32'(ref_mem[b]);
                if (!un && v[7]) v = v | 32'hFFFF_FF00;
            end else if (sz == 2'd1) begin
                v = 32'(ref_mem[b]) + 32'(ref_mem[b+1]) * 256;
                if (!un && v[15]) v = v | 32'hFFFF_0000;
            end else begin
                v = {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
            end
            last_rdata = v;
            e.lat = 2;
        end else begin
            ref_mem[b] = wd[7:0];
            if (sz != 2'd0) ref_mem[b+1] = wd[15:8];
            if (sz == 2'd2) begin
                ref_mem[b+2] = wd[23:16];
                ref_mem[b+3] = wd[31:24];
            end
            exp_writes++;
            e.lat = (sz == 2'd2) ? 2 : 3;
        end
        e.err    = err;
        e.rdata  = last_rdata;
        e.writes = exp_writes;
        e.name   = nm;
        e.issue  = cyc;
        Store = st; Size = sz; Unsigned = un; Addr = a; WData = wd;
        Start = 1'b1;
        sb.push_back(e);
        @(negedge CLK);
        #2;
        // Optional junk request while busy; it must be ignored.
        Start = poke;
        Store = 1'($urandom);
        Size = 2'($urandom);
        Addr = $urandom;
        WData = $urandom;
        @(negedge CLK);
        #2;
        Start = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge CLK);
            #2;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_done_timeout actual=none required=done", nm);
            sb.delete();
        end
    endtask

    // Reset during RMW (sb=1) or during WR (sb=0): no write, no Done.
    task automatic rst_mid(input string nm, input bit sub);
        wait_idle();
        Store = 1'b1; Size = sub ? 2'd0 : 2'd2; Unsigned = 1'b0;
        Addr = 32'd100; WData = 32'hA5A5_5A5A;
        Start = 1'b1;
        @(negedge CLK);
        #2;
        Start = 1'b0;
        if (!sub) chk({nm, "_memrw_hi"}, 32'(MemRW), 32'd1);
        Reset_n = 1'b0;
        #1;
        chk({nm, "_memrw"}, 32'(MemRW), 32'd0);
        chk({nm, "_busy"}, 32'(Busy), 32'd0);
        chk({nm, "_done"}, 32'(Done), 32'd0);
        repeat (2) @(negedge CLK);
        #2;
        Reset_n = 1'b1;
        last_rdata = '0;
        chk({nm, "_rdata"}, RData, 32'd0);
        chk({nm, "_mem"}, mem_diff(), 0);
        chk({nm, "_wrcnt"}, wr_cnt, exp_writes);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[0] = 8'h80; mem[1] = 8'h7F; mem[2] = 8'hFF; mem[3] = 8'h01;
        for (int i = 0; i < 4; i++) ref_mem[i] = mem[i];
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_adderr", 32'(AddrErr), 32'd0);
        chk("rst_rdata", RData, 32'd0);
        chk("rst_memrw", 32'(MemRW), 32'd0);
        chk("rst_memaddr", MemAddr, 32'd0);
        chk("rst_memwdata", MemWData, 32'd0);
        repeat (2) @(negedge CLK);
        #2;
        Reset_n = 1'b1;

        do_op("lb0", 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("lb0_const", RData, 32'hFFFF_FF80);
        do_op("lbu0", 1'b0, 2'd0, 1'b1, 32'd0, 32'd0, 1'b1);
        chk("lbu0_const", RData, 32'h0000_0080);
        do_op("lhu2", 1'b0, 2'd1, 1'b1, 32'd2, 32'd0, 1'b0);
        chk("lhu2_const", RData, 32'h0000_01FF);
        do_op("lh0", 1'b0, 2'd1, 1'b0, 32'd0, 32'd0, 1'b1);
        chk("lh0_const", RData, 32'h0000_7F80);
        do_op("sw8", 1'b1, 2'd2, 1'b0, 32'd8, 32'hDEAD_BEEF, 1'b1);
        chk("sw8_const", mem_word(8), 32'hDEAD_BEEF);
        do_op("lw8", 1'b0, 2'd2, 1'b0, 32'd8, 32'd0, 1'b0);
        chk("lw8_const", RData, 32'hDEAD_BEEF);
        do_op("sb9", 1'b1, 2'd0, 1'b0, 32'd9, 32'h11, 1'b1);
        chk("sb9_const", mem_word(8), 32'hDEAD_11EF);
        do_op("sh10", 1'b1, 2'd1, 1'b0, 32'd10, 32'h2233, 1'b0);
        chk("sh10_const", mem_word(8), 32'h2233_11EF);
        do_op("lw2_err", 1'b0, 2'd2, 1'b0, 32'd2, 32'd0, 1'b1);
        do_op("lh1_err", 1'b0, 2'd1, 1'b0, 32'd1, 32'd0, 1'b0);
        do_op("rsv_err", 1'b1, 2'd3, 1'b0, 32'd8, 32'h5555_5555, 1'b1);
        chk("err_rdata_const", RData, 32'hDEAD_BEEF);
`ifdef LSU_BOUND_CHECK_EN
        do_op("sw1024_err", 1'b1, 2'd2, 1'b0, 32'd1024, 32'h1234_5678, 1'b0);
`endif
        rst_mid("rst_rmw", 1'b1);
        rst_mid("rst_wr", 1'b0);

        for (int n = 0; n < 250; n++) begin
            do_op("rnd", 1'($urandom), 2'($urandom), 1'($urandom),
                  32'($urandom_range(0, 1023)), $urandom, 1'($urandom));
        end

        wait_idle();
        repeat (2) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
